// File: rtl/pipe_reg.sv
// pipe_reg: elastic pipeline register chain of DEPTH stages with valid/ready
// handshake, per-stage valid bits so bubbles collapse, synchronous flush and
// a registered occupancy count.
// Integration note: out_ready reaches in_ready combinationally through the
// ready chain (depth grows with DEPTH). Do not close a ready loop around it.
module pipe_reg #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 3
) (
  input  logic                       clk,
  input  logic                       r,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] v_d;
  logic [DEPTH-1:0] v_in;
  logic [DEPTH-1:0] rdy;
  logic [WIDTH-1:0] data_q  [DEPTH];
  logic [WIDTH-1:0] data_in [DEPTH];
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;

  // Ready chain: a stage can advance if it is empty or its successor advances.
  always_comb begin
    logic chain;
    rdy          = '0;
    chain        = !v_q[DEPTH-1] || out_ready;
    rdy[DEPTH-1] = chain;
    for (int unsigned k = 1; k < DEPTH; k++) begin
      chain            = !v_q[DEPTH-1-k] || chain;
      rdy[DEPTH-1-k]   = chain;
    end
  end

  // Handshake outputs are forced low during flush and reset.
  assign in_ready  = rdy[0] && !flush && !r;
  assign out_valid = v_q[DEPTH-1] && !flush && !r;
  assign out_data  = data_q[DEPTH-1];
  assign count     = count_q;

  // Incoming valid/data per stage: stage 0 from the input transfer, others from the predecessor.
  always_comb begin
    v_in       = '0;
    data_in    = '{default: '0};
    v_in[0]    = in_valid && in_ready;
    data_in[0] = in_data;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      v_in[i]    = v_q[i-1];
      data_in[i] = data_q[i-1];
    end
  end

  // Next valid bits and their popcount, so count tracks v[] on the same edge.
  always_comb begin
    v_d     = v_q;
    count_d = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (rdy[i]) begin
        v_d[i] = v_in[i];
      end
      count_d = count_d + CW'(v_d[i]);
    end
  end

  // Stage registers: reset clears everything, flush clears valids only, data loads only on valid.
  always_ff @(posedge clk) begin
    if (r) begin
      v_q     <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
    end else if (flush) begin
      v_q     <= '0;
      count_q <= '0;
    end else begin
      v_q     <= v_d;
      count_q <= count_d;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (rdy[i] && v_in[i]) begin
          data_q[i] <= data_in[i];
        end
      end
    end
  end

endmodule
